// File: rtl/i2c_scl_timing_gen.sv
// I2C SCL generator: open-drain SCL drive, quarter-phase ticks, clock stretching and stretch timeout.
// Latency: registered outputs follow the FSM with no extra delay; SCL_IN reaches the FSM after a 2-flop synchroniser.
// Backpressure: a slave holding SCL low stalls the high half in HWAIT until release or STRETCH_MAX cycles.
module i2c_scl_timing_gen #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int SCL_FREQ_HZ = 100000,
    parameter int QUARTER     = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ),
    parameter int CNT_W       = 16,
    parameter int STRETCH_MAX = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       SCL_IN,
    output logic       SCL_OE,
    output logic [1:0] PHASE,
    output logic       TICK,
    output logic       BUSY,
    output logic       STRETCH,
    output logic       TIMEOUT
);

    localparam logic [CNT_W-1:0] Q_LOAD = CNT_W'(QUARTER - 1);
    localparam logic [CNT_W-1:0] S_LIM  = CNT_W'(STRETCH_MAX);
    localparam logic [CNT_W-1:0] S_THR  = CNT_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW1,
        ST_LOW2,
        ST_HWAIT,
        ST_HIGH1,
        ST_HIGH2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] qcnt_q, qcnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d, scnt_inc;
    logic [1:0]       sync_q;
    logic             scl_s;
    logic             timeout_d;
    logic             scl_oe_d, tick_d, busy_d, stretch_d;
    logic [1:0]       phase_d;

    assign scl_s = sync_q[1];

    // Next state, counters and the registered-output values derived from the next state.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        scnt_d    = '0;
        timeout_d = TIMEOUT;
        scnt_inc  = (scnt_q == S_LIM) ? S_LIM : scnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (EN && !TIMEOUT) begin
                    state_d = ST_LOW1;
                    qcnt_d  = Q_LOAD;
                end else if (!EN) begin
                    timeout_d = 1'b0;
                end
            end
            ST_HWAIT: begin
                // A release seen on the limit cycle still wins over the timeout.
                if (scl_s) begin
                    state_d = ST_HIGH1;
                    qcnt_d  = Q_LOAD;
                end else if (scnt_inc == S_LIM) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    scnt_d = scnt_inc;
                end
            end
            default: begin
                if (qcnt_q == '0) begin
                    qcnt_d = Q_LOAD;
                    case (state_q)
                        ST_LOW1:  state_d = ST_LOW2;
                        ST_LOW2:  state_d = ST_HWAIT;
                        ST_HIGH1: state_d = ST_HIGH2;
                        default:  state_d = EN ? ST_LOW1 : ST_IDLE;
                    endcase
                end else begin
                    qcnt_d = qcnt_q - CNT_W'(1);
                end
            end
        endcase

        scl_oe_d  = (state_d == ST_LOW1) || (state_d == ST_LOW2);
        busy_d    = (state_d != ST_IDLE);
        stretch_d = (state_d == ST_HWAIT) && (scnt_d >= S_THR);
        tick_d    = ((state_d == ST_LOW1) || (state_d == ST_LOW2) ||
                     (state_d == ST_HIGH1) || (state_d == ST_HIGH2)) && (qcnt_d == '0);
        case (state_d)
            ST_LOW2:           phase_d = 2'd1;
            ST_HWAIT, ST_HIGH1: phase_d = 2'd2;
            ST_HIGH2:          phase_d = 2'd3;
            default:           phase_d = 2'd0;
        endcase
    end

    // State, counters, synchroniser and registered outputs; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            qcnt_q  <= '0;
            scnt_q  <= '0;
            sync_q  <= 2'b11;
            SCL_OE  <= 1'b0;
            PHASE   <= 2'd0;
            TICK    <= 1'b0;
            BUSY    <= 1'b0;
            STRETCH <= 1'b0;
            TIMEOUT <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            scnt_q  <= scnt_d;
            sync_q  <= {sync_q[0], SCL_IN};
            SCL_OE  <= scl_oe_d;
            PHASE   <= phase_d;
            TICK    <= tick_d;
            BUSY    <= busy_d;
            STRETCH <= stretch_d;
            TIMEOUT <= timeout_d;
        end
    end

endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
`timescale 1ns/1ps
// Bench for i2c_scl_timing_gen: loopback SCL, slave stretch, timeout, EN drop, reset and limit race.
// Expected tick phases/positions are queued before each scenario and popped as TICKs appear.
// The slave model pulls SCL low while hold=1, otherwise SCL follows the released/driven level.
module tb_i2c_scl_timing_gen;

    localparam int S_MAX = 8000;

    logic       clk;
    logic       rst;
    logic       en;
    logic       hold;
    logic       scl_in;
    logic       scl_oe;
    logic [1:0] phase;
    logic       tick;
    logic       busy;
    logic       stretch;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] phase;
        int         at;
    } exp_t;

    exp_t sb[$];

    i2c_scl_timing_gen #(
        .STRETCH_MAX(S_MAX)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .EN      (en),
        .SCL_IN  (scl_in),
        .SCL_OE  (scl_oe),
        .PHASE   (phase),
        .TICK    (tick),
        .BUSY    (busy),
        .STRETCH (stretch),
        .TIMEOUT (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Open-drain wire: low if master drives or slave holds.
    always_comb scl_in = hold ? 1'b0 : ~scl_oe;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; hold = 1'b0;
        repeat (3) step();
        checks++; if (scl_oe !== 1'b0)  begin errors++; $display("FAIL reset_scl_oe got %b want 0", scl_oe); end
        checks++; if (phase !== 2'd0)   begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (tick !== 1'b0)    begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (stretch !== 1'b0) begin errors++; $display("FAIL reset_stretch got %b want 0", stretch); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout); end
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_en busy got %b want 0", busy); end
    endtask

    task automatic test_free_run();
        int oe_hi = 0, oe_lo = 0, busy_lo = 0, str_hi = 0, ntick = 0, w = 0;
        exp_t e;
        sb.delete();
        for (int p = 0; p < 2; p++) begin
            sb.push_back('{2'd0, 125 + 503 * p});
            sb.push_back('{2'd1, 250 + 503 * p});
            sb.push_back('{2'd2, 378 + 503 * p});
            sb.push_back('{2'd3, 503 + 503 * p});
        end
        hold = 1'b0; en = 1'b1;
        for (int i = 1; i <= 1006; i++) begin
            step();
            if (i <= 503) begin
                if (scl_oe) oe_hi++; else oe_lo++;
            end
            if (!busy) busy_lo++;
            if (stretch) str_hi++;
            if (tick) begin
                ntick++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL free_run_extra_tick phase %0d at %0d", phase, i);
                end else begin
                    e = sb.pop_front();
                    if (phase !== e.phase || i != e.at) begin
                        errors++;
                        $display("FAIL free_run_tick got phase %0d at %0d want phase %0d at %0d", phase, i, e.phase, e.at);
                    end
                end
            end
        end
        checks++; if (oe_hi != 250) begin errors++; $display("FAIL free_run_low_time got %0d want 250", oe_hi); end
        checks++; if (oe_lo != 253) begin errors++; $display("FAIL free_run_high_time got %0d want 253", oe_lo); end
        checks++; if (busy_lo != 0) begin errors++; $display("FAIL free_run_busy got %0d idle cycles want 0", busy_lo); end
        checks++; if (str_hi != 0)  begin errors++; $display("FAIL free_run_stretch got %0d cycles want 0", str_hi); end
        checks++; if (ntick != 8 || sb.size() != 0) begin
            errors++; $display("FAIL free_run_tick_count got %0d left %0d want 8 left 0", ntick, sb.size());
        end
        en = 1'b0;
        while (busy && w < 600) begin step(); w++; end
        checks++; if (busy !== 1'b0 || scl_oe !== 1'b0) begin
            errors++; $display("FAIL free_run_stop busy %b scl_oe %b want 0 0", busy, scl_oe);
        end
    endtask

    task automatic test_en_drop();
        int ntick = 0;
        logic dropped = 1'b0;
        exp_t e;
        sb.delete();
        sb.push_back('{2'd0, 125});
        sb.push_back('{2'd1, 250});
        sb.push_back('{2'd2, 378});
        sb.push_back('{2'd3, 503});
        hold = 1'b0; en = 1'b1;
        for (int i = 1; i <= 520; i++) begin
            step();
            if (!dropped && phase == 2'd1) begin en = 1'b0; dropped = 1'b1; end
            if (tick) begin
                ntick++;
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL en_drop_extra_tick phase %0d at %0d", phase, i);
                end else begin
                    e = sb.pop_front();
                    if (phase !== e.phase || i != e.at) begin
                        errors++;
                        $display("FAIL en_drop_tick got phase %0d at %0d want phase %0d at %0d", phase, i, e.phase, e.at);
                    end
                end
            end
            if (i == 504) begin
                checks++;
                if (busy !== 1'b0 || scl_oe !== 1'b0) begin
                    errors++; $display("FAIL en_drop_idle busy %b scl_oe %b want 0 0", busy, scl_oe);
                end
            end
        end
        checks++; if (ntick != 4 || sb.size() != 0) begin
            errors++; $display("FAIL en_drop_tick_count got %0d left %0d want 4 left 0", ntick, sb.size());
        end
    endtask

    task automatic test_stretch();
        int w = 0, str_cnt = 0, first_str = 0, last_str = 0;
        logic to_seen = 1'b0;
        exp_t e;
        hold = 1'b1; en = 1'b1;
        step();
        while (!(busy && !scl_oe) && w < 400) begin step(); w++; end
        checks++;
        if (!(busy && !scl_oe)) begin
            errors++; $display("FAIL stretch_no_release busy %b scl_oe %b", busy, scl_oe);
            return;
        end
        en = 1'b0;
        sb.delete();
        sb.push_back('{2'd2, 1128});
        sb.push_back('{2'd3, 1253});
        for (int h = 1; h <= 1300; h++) begin
            if (h > 1) step();
            if (h == 1001) hold = 1'b0;
            if (stretch) begin
                str_cnt++;
                if (first_str == 0) first_str = h;
                last_str = h;
            end
            if (timeout) to_seen = 1'b1;
            if (tick) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL stretch_extra_tick phase %0d at %0d", phase, h);
                end else begin
                    e = sb.pop_front();
                    if (phase !== e.phase || h != e.at) begin
                        errors++;
                        $display("FAIL stretch_tick got phase %0d at %0d want phase %0d at %0d", phase, h, e.phase, e.at);
                    end
                end
            end
        end
        checks++; if (str_cnt != 1000) begin errors++; $display("FAIL stretch_len got %0d want 1000", str_cnt); end
        checks++; if (first_str != 4 || last_str != 1003) begin
            errors++; $display("FAIL stretch_window got %0d..%0d want 4..1003", first_str, last_str);
        end
        checks++; if (to_seen) begin errors++; $display("FAIL stretch_timeout got 1 want 0"); end
        checks++; if (sb.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL stretch_end left %0d busy %b want 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int w = 0, to_at = 0, busy_cnt = 0, to_cnt = 0;
        logic at_busy = 1'b1, at_oe = 1'b1, at_str = 1'b1;
        int first_tick = 0;
        hold = 1'b1; en = 1'b1;
        step();
        while (!(busy && !scl_oe) && w < 400) begin step(); w++; end
        checks++;
        if (!(busy && !scl_oe)) begin
            errors++; $display("FAIL timeout_no_release busy %b scl_oe %b", busy, scl_oe);
            return;
        end
        for (int h = 1; h <= S_MAX + 20; h++) begin
            if (h > 1) step();
            if (timeout && to_at == 0) begin
                to_at = h; at_busy = busy; at_oe = scl_oe; at_str = stretch;
            end
        end
        checks++; if (to_at != S_MAX + 1) begin errors++; $display("FAIL timeout_at got %0d want %0d", to_at, S_MAX + 1); end
        checks++; if (at_busy !== 1'b0 || at_oe !== 1'b0 || at_str !== 1'b0) begin
            errors++; $display("FAIL timeout_outputs busy %b scl_oe %b stretch %b want 0 0 0", at_busy, at_oe, at_str);
        end
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) busy_cnt++;
            if (timeout) to_cnt++;
        end
        checks++; if (busy_cnt != 0 || to_cnt != 20) begin
            errors++; $display("FAIL timeout_sticky busy %0d timeout %0d want 0 20", busy_cnt, to_cnt);
        end
        en = 1'b0;
        step();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", timeout); end
        en = 1'b1;
        step();
        checks++; if (busy !== 1'b1 || scl_oe !== 1'b1 || phase !== 2'd0) begin
            errors++; $display("FAIL timeout_restart busy %b scl_oe %b phase %0d want 1 1 0", busy, scl_oe, phase);
        end
        for (int i = 2; i <= 130; i++) begin
            step();
            if (tick && first_tick == 0) first_tick = i;
        end
        checks++; if (first_tick != 125) begin errors++; $display("FAIL timeout_restart_tick got %0d want 125", first_tick); end
        en = 1'b0;
        w = 0;
        while (busy && w < 600) begin step(); w++; end
    endtask

    task automatic test_race();
        int w = 0;
        logic to_seen = 1'b0;
        exp_t e;
        hold = 1'b1; en = 1'b1;
        step();
        while (!(busy && !scl_oe) && w < 400) begin step(); w++; end
        checks++;
        if (!(busy && !scl_oe)) begin
            errors++; $display("FAIL race_no_release busy %b scl_oe %b", busy, scl_oe);
            return;
        end
        en = 1'b0;
        sb.delete();
        sb.push_back('{2'd2, S_MAX + 125});
        sb.push_back('{2'd3, S_MAX + 250});
        for (int h = 1; h <= S_MAX + 260; h++) begin
            if (h > 1) step();
            if (h == S_MAX - 2) hold = 1'b0;
            if (timeout) to_seen = 1'b1;
            if (tick) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL race_extra_tick phase %0d at %0d", phase, h);
                end else begin
                    e = sb.pop_front();
                    if (phase !== e.phase || h != e.at) begin
                        errors++;
                        $display("FAIL race_tick got phase %0d at %0d want phase %0d at %0d", phase, h, e.phase, e.at);
                    end
                end
            end
        end
        checks++; if (to_seen) begin errors++; $display("FAIL race_timeout got 1 want 0"); end
        checks++; if (sb.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL race_end left %0d busy %b want 0 0", sb.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int w = 0, first_tick = 0;
        logic [1:0] tick_phase = 2'd3;
        hold = 1'b0; en = 1'b1;
        step();
        while (!(busy && !scl_oe) && w < 400) begin step(); w++; end
        // HWAIT lasts 3 cycles, so h=68 is HIGH1 with 60 cycles left on the counter.
        for (int h = 2; h <= 68; h++) step();
        checks++; if (phase !== 2'd2 || scl_oe !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre phase %0d scl_oe %b busy %b want 2 0 1", phase, scl_oe, busy);
        end
        rst = 1'b1;
        step();
        checks++; if ({scl_oe, phase, tick, busy, stretch, timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got oe %b ph %0d tk %b bz %b st %b to %b want all 0",
                     scl_oe, phase, tick, busy, stretch, timeout);
        end
        rst = 1'b0;
        step();
        checks++; if (scl_oe !== 1'b1 || phase !== 2'd0) begin
            errors++; $display("FAIL reset_mid_restart scl_oe %b phase %0d want 1 0", scl_oe, phase);
        end
        for (int i = 2; i <= 130; i++) begin
            step();
            if (tick && first_tick == 0) begin first_tick = i; tick_phase = phase; end
        end
        checks++; if (first_tick != 125 || tick_phase !== 2'd0) begin
            errors++; $display("FAIL reset_mid_tick got %0d phase %0d want 125 phase 0", first_tick, tick_phase);
        end
        en = 1'b0;
        w = 0;
        while (busy && w < 600) begin step(); w++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_stop busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_en_drop();
        test_stretch();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
